// File: rtl/hsm_axil_regfile.sv
// hsm_axil_regfile: AXI4-Lite slave register file in front of the HSM core.
//   reg0 CTRL   : bit0 START (write-1 pulses cmd_start, reads 0), bit1 IRQ_EN
//   reg1 STATUS : bit0 BUSY (live), bit1 DONE, bit2 TIMEOUT, bit3 CMD_REJ (sticky, W1C)
//   reg2..      : plain RW data registers, byte-strobed, exported on reg_out
// Optional busy watchdog: define HSM_AXIL_TIMEOUT_EN to build the TIMEOUT counter;
// without it STATUS.TIMEOUT is constant 0.
module hsm_axil_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic                                       cmd_start,
  input  logic                                       core_busy,
  input  logic                                       core_done,
  output logic                                       irq,
  output logic [(NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(DW / 8);
  localparam int unsigned IW       = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned ND       = NUM_REGS - 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Ready outputs stay low until the first clock after reset release.
  logic init_q;

  logic          aw_held_q, aw_held_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic          rej_q, rej_d;
  logic          cmd_start_q, cmd_start_d;
  logic          irq_q, irq_d;
  logic          timeout_flag;

  logic [DW-1:0] dreg_q [ND];
  logic [DW-1:0] dreg_d [ND];

  logic          aw_hs, w_hs, ar_hs;
  logic          commit, wr_in_range, wr_ok;
  logic          ctrl_wr, status_wr, start_req;
  logic [IW-1:0] ar_idx;
  logic          rd_in_range;
  logic [DW-1:0] rd_word;

  assign S_AXI_AWREADY = init_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = init_q && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = init_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign cmd_start     = cmd_start_q;
  assign irq           = irq_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A write commits the cycle after both address and data are held.
  assign commit      = aw_held_q && w_held_q;
  assign wr_in_range = 32'(aw_idx_q) < NUM_REGS;
  assign wr_ok       = commit && wr_in_range;
  // CTRL and STATUS only react to byte lane 0.
  assign ctrl_wr     = wr_ok && (aw_idx_q == '0) && w_strb_q[0];
  assign status_wr   = wr_ok && (32'(aw_idx_q) == 32'd1) && w_strb_q[0];
  assign start_req   = ctrl_wr && w_data_q[0];

  assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range = 32'(ar_idx) < NUM_REGS;

  // Write channel: independent AW/W capture, commit, B response hold.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RespOkay : RespSlvErr;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
    end
  end

  // Read data mux; out-of-range indices fall through to zero.
  always_comb begin
    rd_word = '0;
    if (ar_idx == '0) begin
      rd_word[1] = irq_en_q;
    end else if (32'(ar_idx) == 32'd1) begin
      rd_word[3:0] = {rej_q, timeout_flag, done_q, core_busy};
    end
    for (int unsigned i = 0; i < ND; i++) begin
      if (32'(ar_idx) == i + 2) begin
        rd_word = dreg_q[i];
      end
    end
  end

  // Read channel: capture on AR handshake, hold payload until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_in_range ? RespOkay : RespSlvErr;
    end
  end

  // Control/status next state; a same-cycle set beats a W1C clear.
  always_comb begin
    irq_en_d    = ctrl_wr ? w_data_q[1] : irq_en_q;
    cmd_start_d = start_req && !core_busy;
    done_d      = core_done | (done_q & ~(status_wr & w_data_q[1]));
    rej_d       = (start_req && core_busy) | (rej_q & ~(status_wr & w_data_q[3]));
    irq_d       = irq_en_q & (done_q | timeout_flag | rej_q);
  end

  // Byte-strobed writes into the data registers.
  always_comb begin
    dreg_d = dreg_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (wr_ok && (32'(aw_idx_q) == i + 2)) begin
        for (int unsigned b = 0; b < SW; b++) begin
          if (w_strb_q[b]) begin
            dreg_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Channel and control state registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      init_q      <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
      cmd_start_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      init_q      <= 1'b1;
      aw_held_q   <= aw_held_d;
      aw_idx_q    <= aw_idx_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      rej_q       <= rej_d;
      cmd_start_q <= cmd_start_d;
      irq_q       <= irq_d;
    end
  end

  // Data register storage.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < ND; i++) begin
        dreg_q[i] <= '0;
      end
    end else begin
      dreg_q <= dreg_d;
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = dreg_q[g];
  end

`ifdef HSM_AXIL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic          timeout_set;

  // Busy watchdog: saturates, so TIMEOUT fires once per busy episode.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!core_busy) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    timeout_set = (to_cnt_d == TW'(TIMEOUT_CYCLES)) && (to_cnt_q != TW'(TIMEOUT_CYCLES));
    timeout_d   = timeout_set | (timeout_q & ~(status_wr & w_data_q[2]));
  end

  // Watchdog state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                        S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
  assign timeout_flag = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                        S_AXI_ARADDR[ADDR_LSB-1:0], (TIMEOUT_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_hsm_axil_regfile.sv
// Directed bench for hsm_axil_regfile (32-bit data, 6-bit address, 8 regs,
// TIMEOUT_CYCLES=16). Honours HSM_AXIL_TIMEOUT_EN for the watchdog check.
module tb_hsm_axil_regfile;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         cmd_start;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic         irq;
  logic [191:0] reg_out;

  int n_total = 0;
  int n_bad   = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  // Counts cycles in which cmd_start is high.
  always @(posedge clk) begin
    if (cmd_start) start_cnt <= start_cnt + 1;
  end

  hsm_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS          (8),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .cmd_start    (cmd_start),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .irq          (irq),
    .reg_out      (reg_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  n;
    logic aw_ok, w_ok;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_ok = awvalid && awready;
      w_ok  = wvalid && wready;
      step();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok)  wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < 40) begin
      step();
      n++;
    end
    if (!bvalid) check("wr_bvalid_timeout", 64'(bvalid), 64'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      step();
      n++;
    end
    step();
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin
      step();
      n++;
    end
    if (!rvalid) check("rd_rvalid_timeout", 64'(rvalid), 64'd1);
    d = rdata; resp = rresp;
    step();
    rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          s0;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_readys", 64'({awready, wready, arready}), 64'd0);
    check("rst_valids", 64'({bvalid, rvalid, cmd_start, irq}), 64'd0);
    check("rst_payload", 64'({rdata, bresp, rresp}), 64'd0);
    check("rst_reg_out", 64'(|reg_out), 64'd0);
    rst_n = 1'b1;
    step();

    // AW at cycle 0, W at cycle 3; BVALID one cycle after W.
    check("aw_ready", 64'(awready), 64'd1);
    awaddr = 6'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    step();
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("bvalid_not_yet", 64'(bvalid), 64'd0);
    step();
    check("bvalid_after_w", 64'(bvalid), 64'd1);
    check("bresp_okay", 64'(bresp), 64'd0);
    check("reg_out_reg2", 64'(reg_out[31:0]), 64'hDEADBEEF);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_cleared", 64'(bvalid), 64'd0);
    axi_read(6'h08, rd, rs);
    check("rd_reg2", 64'(rd), 64'hDEADBEEF);

    // Byte strobes on reg3: lanes 0 and 2 updated.
    axi_write(6'h0C, 32'h11223344, 4'hF, rs);
    axi_write(6'h0C, 32'hAABBCCDD, 4'h5, rs);
    axi_read(6'h0C, rd, rs);
    check("rd_reg3_strb", 64'(rd), 64'h11BB33DD);
    check("reg_out_reg3", 64'(reg_out[63:32]), 64'h11BB33DD);

    // START + IRQ_EN with core idle, then done pulse.
    s0 = start_cnt;
    axi_write(6'h00, 32'h3, 4'h1, rs);
    repeat (3) step();
    check("start_pulse_cycles", 64'(start_cnt - s0), 64'd1);
    axi_read(6'h00, rd, rs);
    check("ctrl_read", 64'(rd), 64'h2);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("irq_on_done", 64'(irq), 64'd1);
    axi_read(6'h04, rd, rs);
    check("status_done", 64'(rd), 64'h2);
    axi_write(6'h04, 32'h2, 4'h1, rs);
    step();
    check("irq_cleared", 64'(irq), 64'd0);
    axi_read(6'h04, rd, rs);
    check("status_cleared", 64'(rd), 64'h0);

    // START while busy is rejected.
    core_busy = 1'b1;
    s0 = start_cnt;
    axi_write(6'h00, 32'h3, 4'h1, rs);
    repeat (3) step();
    check("no_start_busy", 64'(start_cnt - s0), 64'd0);
    axi_read(6'h04, rd, rs);
    check("status_rej", 64'(rd), 64'h9);

    // core_done lands in the same cycle as a W1C of DONE.
    awaddr = 6'h04; awvalid = 1'b1;
    wdata = 32'h2; wstrb = 4'h1; wvalid = 1'b1;
    bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("w1c_bvalid", 64'(bvalid), 64'd1);
    step();
    bready = 1'b0;
    axi_read(6'h04, rd, rs);
    check("done_set_wins", 64'(rd), 64'hB);
    core_busy = 1'b0;
    axi_write(6'h04, 32'hE, 4'h1, rs);
    axi_read(6'h04, rd, rs);
    check("status_all_clear", 64'(rd), 64'h0);

    // Out-of-range write with BREADY held low.
    awaddr = 6'h20; awvalid = 1'b1;
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("oor_b_hold", 64'({bvalid, bresp, awready, wready}), 64'({1'b1, 2'b10, 2'b00}));
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("oor_b_done", 64'(bvalid), 64'd0);
    check("oor_regs_lo", reg_out[63:0], 64'h11BB33DD_DEADBEEF);
    check("oor_regs_mid", reg_out[127:64], 64'd0);
    check("oor_regs_hi", reg_out[191:128], 64'd0);
    axi_read(6'h20, rd, rs);
    check("oor_rdata", 64'(rd), 64'd0);
    check("oor_rresp", 64'(rs), 64'd2);
    axi_read(6'h1C, rd, rs);
    check("reg7_okay", 64'({rd, rs}), 64'd0);

    // In-range read with RREADY held low.
    araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("r_hold", 64'({rvalid, rdata, rresp, arready}), 64'({1'b1, 32'hDEADBEEF, 3'b000}));
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("r_done", 64'(rvalid), 64'd0);

    // Busy watchdog.
    core_busy = 1'b1;
    repeat (20) step();
    axi_read(6'h04, rd, rs);
`ifdef HSM_AXIL_TIMEOUT_EN
    check("status_timeout", 64'(rd), 64'h5);
    check("irq_timeout", 64'(irq), 64'd1);
`else
    check("status_no_timeout", 64'(rd), 64'h1);
    check("irq_no_timeout", 64'(irq), 64'd0);
`endif
    core_busy = 1'b0;
    axi_write(6'h04, 32'h4, 4'h1, rs);
    axi_read(6'h04, rd, rs);
    check("timeout_cleared", 64'(rd), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
